// File: rtl/tree_walk_classifier.sv
// tree_walk_classifier
//   Walks a cut-tree held in node memory from the root (address 0) down to a
//   leaf, then scans that leaf's rule list in rule memory. The first rule whose
//   every field range contains the matching header field wins.
//
// Ports
//   clk, reset                 clock, asynchronous active-low reset
//   hdr_valid/hdr_ready        header handshake, hdr_data = NUM_FIELDS packed fields
//   res_valid/res_ready        result handshake, result held until consumed
//   res_match, res_rule_id     matching rule and its rule-memory address
//   res_error                  depth, address or field-select fault
//   cfg_node_*                 node memory write port
//   cfg_rule_*                 rule memory write port
//   lookup_count               completed (consumed) lookups, wraps
//
// Node word, LSB first: base[ADDR_W], aux[8], shift[clog2(FIELD_W)],
// fsel[clog2(NUM_FIELDS)], is_leaf. Internal nodes use aux[3:0] as
// lg_children, leaves use aux[7:0] as rule_count.
module tree_walk_classifier #(
    parameter int NUM_FIELDS = 5,
    parameter int FIELD_W    = 32,
    parameter int ADDR_W     = 10,
    parameter int NUM_NODES  = 370,
    parameter int NUM_RULES  = 1024,
    parameter int MAX_DEPTH  = 16,
    localparam int SHIFT_W   = $clog2(FIELD_W),
    localparam int FSEL_W    = $clog2(NUM_FIELDS),
    localparam int NODE_W    = ADDR_W + 8 + SHIFT_W + FSEL_W + 1,
    localparam int HDR_W     = NUM_FIELDS * FIELD_W,
    localparam int RULE_W    = 2 * HDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hdr_valid,
    output logic              hdr_ready,
    input  logic [HDR_W-1:0]  hdr_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_match,
    output logic [ADDR_W-1:0] res_rule_id,
    output logic              res_error,
    input  logic              cfg_node_we,
    input  logic [ADDR_W-1:0] cfg_node_addr,
    input  logic [NODE_W-1:0] cfg_node_wdata,
    input  logic              cfg_rule_we,
    input  logic [ADDR_W-1:0] cfg_rule_addr,
    input  logic [RULE_W-1:0] cfg_rule_wdata,
    output logic [31:0]       lookup_count
);

    localparam int DEPTH_W   = $clog2(MAX_DEPTH + 1);
    localparam int MEM_DEPTH = 1 << ADDR_W;

    localparam logic [ADDR_W:0]      NODE_LIMIT  = (ADDR_W + 1)'(NUM_NODES);
    localparam logic [ADDR_W:0]      RULE_LIMIT  = (ADDR_W + 1)'(NUM_RULES);
    localparam logic [DEPTH_W-1:0]   DEPTH_LIMIT = DEPTH_W'(MAX_DEPTH);
    localparam logic [FIELD_W-1:0]   ONES        = '1;

    typedef enum logic [2:0] {
        IDLE,
        NODE_RD,
        NODE_EV,
        RULE_RD,
        RULE_EV,
        DONE
    } state_t;

    state_t state, state_d;

    // ---------------------------------------------------------------------
    // Memories: synchronous read, one cycle latency, no read/write bypass.
    // ---------------------------------------------------------------------
    logic [NODE_W-1:0] node_mem [MEM_DEPTH];
    logic [RULE_W-1:0] rule_mem [MEM_DEPTH];
    logic [NODE_W-1:0] node_q;
    logic [RULE_W-1:0] rule_q;

    // ---------------------------------------------------------------------
    // Walk state
    // ---------------------------------------------------------------------
    logic [HDR_W-1:0]   hdr_q,       hdr_d;
    logic [ADDR_W-1:0]  node_addr,   node_addr_d;
    logic [DEPTH_W-1:0] depth,       depth_d;
    logic [ADDR_W:0]    rule_addr,   rule_addr_d;
    logic [7:0]         remaining,   remaining_d;
    logic               match_q,     match_d;
    logic               error_q,     error_d;
    logic [ADDR_W-1:0]  rule_id_q,   rule_id_d;
    logic [31:0]        count_q,     count_d;

    logic               rule_in_range;

    assign rule_in_range = (rule_addr < RULE_LIMIT);

    always_ff @(posedge clk) begin
        if (cfg_node_we) begin
            node_mem[cfg_node_addr] <= cfg_node_wdata;
        end
        if (state == NODE_RD) begin
            node_q <= node_mem[node_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (cfg_rule_we) begin
            rule_mem[cfg_rule_addr] <= cfg_rule_wdata;
        end
        if (state == RULE_RD && rule_in_range) begin
            rule_q <= rule_mem[rule_addr[ADDR_W-1:0]];
        end
    end

    // ---------------------------------------------------------------------
    // Node word decode
    // ---------------------------------------------------------------------
    logic [ADDR_W-1:0]  nd_base;
    logic [7:0]         nd_aux;
    logic [SHIFT_W-1:0] nd_shift;
    logic [FSEL_W-1:0]  nd_fsel;
    logic               nd_leaf;

    assign nd_base  = node_q[ADDR_W-1:0];
    assign nd_aux   = node_q[ADDR_W +: 8];
    assign nd_shift = node_q[ADDR_W + 8 +: SHIFT_W];
    assign nd_fsel  = node_q[ADDR_W + 8 + SHIFT_W +: FSEL_W];
    assign nd_leaf  = node_q[NODE_W-1];

    // Field selected by the current node; fsel_ok is low when fsel names a
    // field that does not exist.
    logic [FIELD_W-1:0] sel_field;
    logic               fsel_ok;

    always_comb begin
        sel_field = '0;
        fsel_ok   = 1'b0;
        for (int unsigned i = 0; i < NUM_FIELDS; i++) begin
            if (nd_fsel == FSEL_W'(i)) begin
                sel_field = hdr_q[i*FIELD_W +: FIELD_W];
                fsel_ok   = 1'b1;
            end
        end
    end

    // Child index and address. The sum is kept one bit wider than the
    // address so that base + idx past the top of memory is still caught by
    // the range check rather than wrapping to a low node.
    logic [FIELD_W-1:0] child_mask;
    logic [FIELD_W-1:0] child_idx;
    logic [ADDR_W:0]    next_node;

    assign child_mask = ~(ONES << nd_aux[3:0]);
    assign child_idx  = (sel_field >> nd_shift) & child_mask;
    assign next_node  = {1'b0, nd_base} + child_idx[ADDR_W:0];

    // Rule compare: every field must lie inside [lo, hi], unsigned.
    logic rule_hit;

    always_comb begin
        rule_hit = 1'b1;
        for (int unsigned i = 0; i < NUM_FIELDS; i++) begin
            if (hdr_q[i*FIELD_W +: FIELD_W] < rule_q[2*FIELD_W*i +: FIELD_W] ||
                hdr_q[i*FIELD_W +: FIELD_W] > rule_q[2*FIELD_W*i + FIELD_W +: FIELD_W]) begin
                rule_hit = 1'b0;
            end
        end
    end

    // ---------------------------------------------------------------------
    // FSM: state and walk registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            hdr_q     <= '0;
            node_addr <= '0;
            depth     <= '0;
            rule_addr <= '0;
            remaining <= '0;
            match_q   <= 1'b0;
            error_q   <= 1'b0;
            rule_id_q <= '0;
            count_q   <= '0;
        end else begin
            state     <= state_d;
            hdr_q     <= hdr_d;
            node_addr <= node_addr_d;
            depth     <= depth_d;
            rule_addr <= rule_addr_d;
            remaining <= remaining_d;
            match_q   <= match_d;
            error_q   <= error_d;
            rule_id_q <= rule_id_d;
            count_q   <= count_d;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next state and walk updates
    // ---------------------------------------------------------------------
    always_comb begin
        state_d     = state;
        hdr_d       = hdr_q;
        node_addr_d = node_addr;
        depth_d     = depth;
        rule_addr_d = rule_addr;
        remaining_d = remaining;
        match_d     = match_q;
        error_d     = error_q;
        rule_id_d   = rule_id_q;
        count_d     = count_q;

        case (state)
            IDLE: begin
                if (hdr_valid) begin
                    hdr_d       = hdr_data;
                    node_addr_d = '0;
                    depth_d     = '0;
                    match_d     = 1'b0;
                    error_d     = 1'b0;
                    rule_id_d   = '0;
                    state_d     = NODE_RD;
                end
            end

            NODE_RD: begin
                state_d = NODE_EV;
            end

            NODE_EV: begin
                if (!fsel_ok) begin
                    error_d = 1'b1;
                    state_d = DONE;
                end else if (!nd_leaf) begin
                    if (next_node >= NODE_LIMIT || depth == DEPTH_LIMIT) begin
                        error_d = 1'b1;
                        state_d = DONE;
                    end else begin
                        depth_d     = depth + DEPTH_W'(1);
                        node_addr_d = next_node[ADDR_W-1:0];
                        state_d     = NODE_RD;
                    end
                end else if (nd_aux == 8'd0) begin
                    state_d = DONE;
                end else begin
                    rule_addr_d = {1'b0, nd_base};
                    remaining_d = nd_aux;
                    state_d     = RULE_RD;
                end
            end

            RULE_RD: begin
                if (!rule_in_range) begin
                    error_d = 1'b1;
                    state_d = DONE;
                end else begin
                    state_d = RULE_EV;
                end
            end

            RULE_EV: begin
                if (rule_hit) begin
                    match_d   = 1'b1;
                    rule_id_d = rule_addr[ADDR_W-1:0];
                    state_d   = DONE;
                end else if (remaining == 8'd1) begin
                    state_d = DONE;
                end else begin
                    remaining_d = remaining - 8'd1;
                    rule_addr_d = rule_addr + (ADDR_W + 1)'(1);
                    state_d     = RULE_RD;
                end
            end

            DONE: begin
                if (res_ready) begin
                    count_d   = count_q + 32'd1;
                    match_d   = 1'b0;
                    error_d   = 1'b0;
                    rule_id_d = '0;
                    state_d   = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign hdr_ready    = (state == IDLE);
    assign res_valid    = (state == DONE);
    assign res_match    = match_q;
    assign res_error    = error_q;
    assign res_rule_id  = rule_id_q;
    assign lookup_count = count_q;

endmodule

// File: tb/tb_tree_walk_classifier.sv
// Testbench for tree_walk_classifier: loads a fixed set of nodes and rules,
// then rewrites the root node per vector and checks each lookup against the
// expected result, latency and lookup count. Extra sequences cover result
// backpressure and asynchronous reset in the middle of a rule scan.
module tb_tree_walk_classifier;

    localparam int NF     = 5;
    localparam int FW     = 32;
    localparam int AW     = 10;
    localparam int NODE_W = 27;
    localparam int HDR_W  = NF * FW;
    localparam int RULE_W = 2 * HDR_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              hdr_valid;
    logic              hdr_ready;
    logic [HDR_W-1:0]  hdr_data;
    logic              res_valid;
    logic              res_ready;
    logic              res_match;
    logic [AW-1:0]     res_rule_id;
    logic              res_error;
    logic              cfg_node_we;
    logic [AW-1:0]     cfg_node_addr;
    logic [NODE_W-1:0] cfg_node_wdata;
    logic              cfg_rule_we;
    logic [AW-1:0]     cfg_rule_addr;
    logic [RULE_W-1:0] cfg_rule_wdata;
    logic [31:0]       lookup_count;

    always #5 clk = ~clk;

    tree_walk_classifier #(
        .NUM_FIELDS (NF),
        .FIELD_W    (FW),
        .ADDR_W     (AW),
        .NUM_NODES  (370),
        .NUM_RULES  (1024),
        .MAX_DEPTH  (16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .hdr_valid      (hdr_valid),
        .hdr_ready      (hdr_ready),
        .hdr_data       (hdr_data),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_match      (res_match),
        .res_rule_id    (res_rule_id),
        .res_error      (res_error),
        .cfg_node_we    (cfg_node_we),
        .cfg_node_addr  (cfg_node_addr),
        .cfg_node_wdata (cfg_node_wdata),
        .cfg_rule_we    (cfg_rule_we),
        .cfg_rule_addr  (cfg_rule_addr),
        .cfg_rule_wdata (cfg_rule_wdata),
        .lookup_count   (lookup_count)
    );

    typedef struct {
        string       name;
        bit          leaf;
        int          fsel;
        int          shift;
        int          aux;
        int          base;
        logic [31:0] f0;
        logic [31:0] f1;
        bit          exp_match;
        bit          exp_err;
        int          exp_id;
        int          exp_lat;   // 0: latency not checked
    } vec_t;

    typedef struct packed {
        logic          m;
        logic          e;
        logic [AW-1:0] id;
    } res_t;

    res_t exp_q[$];
    vec_t vecs[19];

    int checks    = 0;
    int errors    = 0;
    int exp_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string n, input bit leaf, input int fsel, input int shift,
                                input int aux, input int base, input logic [31:0] f0,
                                input logic [31:0] f1, input bit m, input bit e,
                                input int id, input int lat);
        vec_t v;
        v.name = n; v.leaf = leaf; v.fsel = fsel; v.shift = shift; v.aux = aux; v.base = base;
        v.f0 = f0; v.f1 = f1; v.exp_match = m; v.exp_err = e; v.exp_id = id; v.exp_lat = lat;
        return v;
    endfunction

    function automatic logic [NODE_W-1:0] node_word(input bit leaf, input int fsel, input int shift,
                                                    input int aux, input int base);
        logic [2:0] fs;
        logic [4:0] sh;
        logic [7:0] ax;
        logic [9:0] bs;
        fs = 3'(fsel); sh = 5'(shift); ax = 8'(aux); bs = 10'(base);
        return {leaf, fs, sh, ax, bs};
    endfunction

    // Field 0 restricted to [lo0, hi0]; all other fields accept everything.
    function automatic logic [RULE_W-1:0] rule_word(input logic [31:0] lo0, input logic [31:0] hi0);
        logic [RULE_W-1:0] w;
        for (int i = 0; i < NF; i++) begin
            w[2*FW*i +: FW]      = 32'h0000_0000;
            w[2*FW*i + FW +: FW] = 32'hFFFF_FFFF;
        end
        w[0 +: FW]  = lo0;
        w[FW +: FW] = hi0;
        return w;
    endfunction

    function automatic logic [HDR_W-1:0] make_hdr(input logic [31:0] f0, input logic [31:0] f1);
        logic [HDR_W-1:0] h;
        for (int i = 0; i < NF; i++) h[i*FW +: FW] = 32'h1234_5678;
        h[0 +: FW]  = f0;
        h[FW +: FW] = f1;
        return h;
    endfunction

    task automatic write_node(input int addr, input logic [NODE_W-1:0] w);
        @(negedge clk);
        cfg_node_we = 1'b1; cfg_node_addr = AW'(addr); cfg_node_wdata = w;
        @(posedge clk); #1;
        cfg_node_we = 1'b0;
    endtask

    task automatic write_rule(input int addr, input logic [RULE_W-1:0] w);
        @(negedge clk);
        cfg_rule_we = 1'b1; cfg_rule_addr = AW'(addr); cfg_rule_wdata = w;
        @(posedge clk); #1;
        cfg_rule_we = 1'b0;
    endtask

    // Latency counts rising edges from the accepting edge (inclusive) up to
    // the edge after which res_valid is seen.
    task automatic run_lookup(input vec_t v, input int hold_cycles);
        res_t exp;
        int   lat;
        write_node(0, node_word(v.leaf, v.fsel, v.shift, v.aux, v.base));
        @(negedge clk);
        check({v.name, " hdr_ready"}, 32'(hdr_ready), 32'd1);
        hdr_data  = make_hdr(v.f0, v.f1);
        hdr_valid = 1'b1;
        res_ready = (hold_cycles == 0);
        exp_q.push_back(res_t'{m: v.exp_match, e: v.exp_err, id: AW'(v.exp_id)});
        @(posedge clk); #1;
        hdr_valid = 1'b0;
        lat = 1;
        while (!res_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!res_valid) begin
            check({v.name, " timeout res_valid"}, 32'(res_valid), 32'd1);
            void'(exp_q.pop_front());
            res_ready = 1'b1;
            return;
        end
        if (exp_q.size() == 0) begin
            check({v.name, " scoreboard empty"}, 32'd0, 32'd1);
            return;
        end
        exp = exp_q.pop_front();
        check({v.name, " res_match"},   32'(res_match),   32'(exp.m));
        check({v.name, " res_error"},   32'(res_error),   32'(exp.e));
        check({v.name, " res_rule_id"}, 32'(res_rule_id), 32'(exp.id));
        if (v.exp_lat != 0) check({v.name, " latency"}, 32'(lat), 32'(v.exp_lat));
        for (int i = 0; i < hold_cycles; i++) begin
            @(posedge clk); #1;
            check({v.name, " held outputs"},
                  32'({res_valid, hdr_ready, res_match, res_error, res_rule_id}),
                  32'({1'b1, 1'b0, exp.m, exp.e, exp.id}));
            check({v.name, " held count"}, lookup_count, 32'(exp_count));
        end
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk); #1;
        exp_count++;
        check({v.name, " res_valid drop"}, 32'(res_valid), 32'd0);
        check({v.name, " back to idle"},   32'(hdr_ready), 32'd1);
        check({v.name, " lookup_count"},   lookup_count,   32'(exp_count));
    endtask

    initial begin
        reset = 1'b0; hdr_valid = 1'b0; hdr_data = '0; res_ready = 1'b1;
        cfg_node_we = 1'b0; cfg_node_addr = '0; cfg_node_wdata = '0;
        cfg_rule_we = 1'b0; cfg_rule_addr = '0; cfg_rule_wdata = '0;

        //           name          leaf fsel sh aux base  f0            f1            m  e  id  lat
        vecs[0]  = mk("single_leaf", 1, 0, 0,  1,   0, 32'h12345678, 32'h12345678, 1, 0,  0,  5);
        vecs[1]  = mk("cut_idx2",    0, 1, 28, 2,   1, 32'h12345678, 32'h2ABCDEF0, 1, 0, 12,  7);
        vecs[2]  = mk("cut_idx0",    0, 1, 28, 2,   1, 32'h12345678, 32'h0FFFFFFF, 1, 0, 10,  7);
        vecs[3]  = mk("cut_idx3",    0, 1, 28, 2,   1, 32'h12345678, 32'hF0000000, 1, 0, 13,  7);
        vecs[4]  = mk("prio_21",     1, 0, 0,  3,  20, 32'h00001234, 32'h0,        1, 0, 21,  7);
        vecs[5]  = mk("prio_lo_edge",1, 0, 0,  3,  20, 32'h00000100, 32'h0,        1, 0, 21,  7);
        vecs[6]  = mk("prio_hi_edge",1, 0, 0,  3,  20, 32'h0000FFFF, 32'h0,        1, 0, 21,  7);
        vecs[7]  = mk("prio_22",     1, 0, 0,  3,  20, 32'h00010000, 32'h0,        1, 0, 22,  9);
        vecs[8]  = mk("prio_20",     1, 0, 0,  3,  20, 32'h0000000F, 32'h0,        1, 0, 20,  5);
        vecs[9]  = mk("prio_miss",   1, 0, 0,  3,  20, 32'h00000050, 32'h0,        0, 0,  0,  9);
        vecs[10] = mk("leaf_empty",  1, 0, 0,  0,  20, 32'h00000050, 32'h0,        0, 0,  0,  3);
        vecs[11] = mk("child_400",   0, 0, 0,  2, 398, 32'h00000002, 32'h0,        0, 1,  0,  3);
        vecs[12] = mk("child_369",   0, 0, 0,  2, 368, 32'h00000001, 32'h0,        1, 0,  0,  7);
        vecs[13] = mk("child_370",   0, 0, 0,  2, 368, 32'h00000002, 32'h0,        0, 1,  0,  3);
        vecs[14] = mk("self_loop",   0, 0, 0,  0,   0, 32'h00000000, 32'h0,        0, 1,  0, 35);
        vecs[15] = mk("chain_16",    0, 0, 0,  0, 101, 32'h00000000, 32'h0,        1, 0,  0, 37);
        vecs[16] = mk("chain_17",    0, 0, 0,  0, 100, 32'h00000000, 32'h0,        0, 1,  0, 35);
        vecs[17] = mk("fsel_7",      0, 7, 0,  2,   1, 32'h00000000, 32'h0,        0, 1,  0,  3);
        vecs[18] = mk("rule_oob",    1, 0, 0,  2,1023, 32'h00000005, 32'h0,        0, 1,  0,  6);

        repeat (3) @(posedge clk);
        #1;
        check("reset hdr_ready",    32'(hdr_ready),   32'd1);
        check("reset res_valid",    32'(res_valid),   32'd0);
        check("reset res_match",    32'(res_match),   32'd0);
        check("reset res_error",    32'(res_error),   32'd0);
        check("reset res_rule_id",  32'(res_rule_id), 32'd0);
        check("reset lookup_count", lookup_count,     32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Rules: 0 and 10..13 accept everything; 20..22 form the priority
        // list; 1023 only matches field0 == FFFFFFFF.
        write_rule(0, rule_word(32'h0, 32'hFFFFFFFF));
        for (int i = 10; i <= 13; i++) write_rule(i, rule_word(32'h0, 32'hFFFFFFFF));
        write_rule(20, rule_word(32'h0,        32'h0000000F));
        write_rule(21, rule_word(32'h00000100, 32'h0000FFFF));
        write_rule(22, rule_word(32'h00000100, 32'hFFFFFFFF));
        write_rule(1023, rule_word(32'hFFFFFFFF, 32'hFFFFFFFF));

        // Nodes: 1..4 leaves onto rules 10..13; 369 leaf onto rule 0;
        // 100..115 a single-child chain ending at leaf 116 (rule 0).
        for (int i = 1; i <= 4; i++) write_node(i, node_word(1'b1, 0, 0, 1, 9 + i));
        write_node(369, node_word(1'b1, 0, 0, 1, 0));
        for (int i = 100; i <= 115; i++) write_node(i, node_word(1'b0, 0, 0, 0, i + 1));
        write_node(116, node_word(1'b1, 0, 0, 1, 0));

        for (int i = 0; i < 19; i++) run_lookup(vecs[i], 0);

        // Result held under backpressure for 10 cycles.
        run_lookup(vecs[1], 10);

        // Reset while the first rule read is being issued.
        write_node(0, node_word(1'b1, 0, 0, 3, 20));
        @(negedge clk);
        hdr_data  = make_hdr(32'h00000050, 32'h0);
        hdr_valid = 1'b1;
        res_ready = 1'b1;
        @(posedge clk); #1;
        hdr_valid = 1'b0;
        check("midwalk busy", 32'(hdr_ready), 32'd0);
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        exp_count = 0;
        exp_q.delete();
        check("midreset hdr_ready",    32'(hdr_ready),   32'd1);
        check("midreset res_valid",    32'(res_valid),   32'd0);
        check("midreset res_match",    32'(res_match),   32'd0);
        check("midreset res_error",    32'(res_error),   32'd0);
        check("midreset res_rule_id",  32'(res_rule_id), 32'd0);
        check("midreset lookup_count", lookup_count,     32'd0);
        @(negedge clk);
        reset = 1'b1;
        run_lookup(vecs[4], 0);
        run_lookup(vecs[1], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
